noc_inject_arbiter: RTL

Packet-level round-robin arbiter that shares one NoC local injection port (sender_valid/ready/flit/is_header/is_tail) among NUM_REQ local requesters, e.g. several traffic generators or NIs on one router node. Grant is taken on a header flit and held, wormhole style, until that packet's tail flit is accepted. The block also flags framing violations and over-long packets.

---
 rtl/noc_arb_pkg.sv | 14 +
 rtl/noc_inject_arbiter_rr_pick.sv | 26 ++
 rtl/noc_inject_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types for the NoC injection arbiter: FSM state encoding and grant-id sizing.
package noc_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // A 1-wide id keeps ports legal even for a degenerate single-requester build.
  function automatic int arb_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr_i, wrapping upward.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] winner_o,
  output logic          any_valid_o
);

  always_comb begin
    int idx;
    idx         = 0;
    winner_o    = '0;
    any_valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!any_valid_o && req_i[idx]) begin
        winner_o    = IW'(idx);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin arbiter sharing one NoC injection port; grant held from header to tail.
// Forwarding is combinational once locked; one idle arbitration cycle separates packets.
module noc_inject_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_FLITS  = 16,
  parameter int ID_W       = arb_id_w(NUM_REQ)
) (
  input  logic                          noc_clk,
  input  logic                          noc_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ-1:0]            req_is_header,
  input  logic [NUM_REQ-1:0]            req_is_tail,
  output logic                          sender_valid,
  input  logic                          sender_ready,
  output logic [DATA_WIDTH-1:0]         sender_flit,
  output logic                          sender_is_header,
  output logic                          sender_is_tail,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          err_frame,
  output logic                          err_len
);

  localparam int              CNT_W   = $clog2(MAX_FLITS + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_FLITS + 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_frame_q, err_frame_d;
  logic             err_len_q, err_len_d;

  logic [NUM_REQ-1:0] cand;
  logic [ID_W-1:0]    winner;
  logic               any_cand;

  assign cand = req_valid & req_is_header;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_pick (
    .req_i       (cand),
    .ptr_i       (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_cand)
  );

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_ptr_d         = rr_ptr_q;
    cnt_d            = cnt_q;
    err_frame_d      = err_frame_q;
    err_len_d        = err_len_q;
    req_ready        = '0;
    sender_valid     = 1'b0;
    sender_flit      = '0;
    sender_is_header = 1'b0;
    sender_is_tail   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // Stray body flits are swallowed so a broken requester cannot wedge the port.
        req_ready = req_valid & ~req_is_header;
        if (|req_ready) err_frame_d = 1'b1;
        if (any_cand) begin
          grant_d = winner;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        sender_valid       = req_valid[grant_q];
        sender_flit        = req_flit[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        sender_is_header   = req_is_header[grant_q];
        sender_is_tail     = req_is_tail[grant_q];
        req_ready[grant_q] = sender_ready;
        if (sender_valid && sender_ready) begin
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_SAT) err_len_d = 1'b1;
          if (cnt_q != '0 && sender_is_header) err_frame_d = 1'b1;
          if (sender_is_tail) begin
            state_d  = ARB_IDLE;
            cnt_d    = '0;
            rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      err_frame_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      err_frame_q <= err_frame_d;
      err_len_q   <= err_len_d;
    end
  end

  assign busy      = (state_q == ARB_LOCKED);
  assign grant_id  = busy ? grant_q : '0;
  assign err_frame = err_frame_q;
  assign err_len   = err_len_q;

endmodule
